// File: rtl/memory_cycle_hs.sv
// -----------------------------------------------------------------------------
// memory_cycle_hs
// Memory pipeline stage with a handshaked (req/ack) data-memory port.
// Takes the E/M register outputs, performs a load or store over the bus while
// stalling the upstream stages, and drives the M/W pipeline register.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   -> BUSY aborts after TIMEOUT_CYCLES cycles without ack; the
//                instruction retires with RegWriteW=0, BusErrW=1, ReadDataW=0.
//   undefined -> BUSY waits indefinitely; BusErrW is tied 0.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   RegWriteM .. ALU_ResultM   M-stage inputs (stable while StallM=1)
//   dmem_req/we/addr/wdata     registered bus request outputs
//   dmem_ack, dmem_rdata       bus completion and read data (used in BUSY only)
//   StallM                     combinational stall for F/D/E
//   RegWriteW .. BusErrW       M/W pipeline register outputs
// -----------------------------------------------------------------------------
module memory_cycle_hs #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        BusErrW
);

    // Legal timeout range is 2..255 (the counter is 8 bits wide).
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("memory_cycle_hs: TIMEOUT_CYCLES out of range 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        reg_write_w_q, reg_write_w_d;
    logic        result_src_w_q, result_src_w_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic [31:0] pc_plus4_w_q, pc_plus4_w_d;
    logic [31:0] alu_result_w_q, alu_result_w_d;
    logic [31:0] read_data_w_q, read_data_w_d;

    logic        access_s;
    logic        timeout_s;
    logic        err_s;

    assign access_s = MemWriteM | ResultSrcM;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       tmo_err_q, tmo_err_d;
    logic       bus_err_w_q, bus_err_w_d;

    // Ack has priority: a timeout only fires on a BUSY cycle with no ack.
    assign timeout_s = (state_q == S_BUSY) && !dmem_ack && (tmo_cnt_q == TO_LAST);
    assign err_s     = tmo_err_q;
    assign BusErrW   = bus_err_w_q;

    // Timeout counter, sticky error flag for the aborted access, BusErrW next value.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;
        bus_err_w_d = bus_err_w_q;
        case (state_q)
            S_IDLE: begin
                tmo_cnt_d   = 8'd0;
                tmo_err_d   = 1'b0;
                bus_err_w_d = 1'b0;
            end
            S_BUSY: begin
                if (dmem_ack) begin
                    tmo_err_d = 1'b0;
                end else if (timeout_s) begin
                    tmo_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                bus_err_w_d = tmo_err_q;
                tmo_err_d   = 1'b0;
            end
            default: begin
                tmo_cnt_d   = 8'd0;
                tmo_err_d   = 1'b0;
                bus_err_w_d = 1'b0;
            end
        endcase
    end

    // Timeout state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q   <= 8'd0;
            tmo_err_q   <= 1'b0;
            bus_err_w_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
            bus_err_w_q <= bus_err_w_d;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign err_s     = 1'b0;
    assign BusErrW   = 1'b0;
`endif

    // Stall while a request is being launched and for every BUSY cycle.
    assign StallM = (state_q == S_BUSY) || ((state_q == S_IDLE) && access_s);

    // FSM next state, bus request latching and M/W register next values.
    always_comb begin
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        rdata_d        = rdata_q;
        reg_write_w_d  = reg_write_w_q;
        result_src_w_d = result_src_w_q;
        rd_w_d         = rd_w_q;
        pc_plus4_w_d   = pc_plus4_w_q;
        alu_result_w_d = alu_result_w_q;
        read_data_w_d  = read_data_w_q;
        case (state_q)
            S_IDLE: begin
                if (access_s) begin
                    // Launch the access; the M/W register takes a bubble.
                    dmem_req_d    = 1'b1;
                    dmem_we_d     = MemWriteM;
                    dmem_addr_d   = ALU_ResultM;
                    dmem_wdata_d  = WriteDataM;
                    reg_write_w_d = 1'b0;
                    state_d       = S_BUSY;
                end else begin
                    // Plain ALU op passes through; ReadDataW keeps its value.
                    reg_write_w_d  = RegWriteM;
                    result_src_w_d = ResultSrcM;
                    rd_w_d         = RD_M;
                    pc_plus4_w_d   = PCPlus4M;
                    alu_result_w_d = ALU_ResultM;
                end
            end
            S_BUSY: begin
                if (dmem_ack) begin
                    rdata_d    = dmem_rdata;
                    dmem_req_d = 1'b0;
                    state_d    = S_DONE;
                end else if (timeout_s) begin
                    rdata_d    = 32'd0;
                    dmem_req_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                // dmem_we_q still describes the finished access.
                reg_write_w_d  = RegWriteM & ~err_s;
                result_src_w_d = ResultSrcM;
                rd_w_d         = RD_M;
                pc_plus4_w_d   = PCPlus4M;
                alu_result_w_d = ALU_ResultM;
                read_data_w_d  = dmem_we_q ? 32'd0 : rdata_q;
                state_d        = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // FSM, bus port and M/W pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= 32'd0;
            dmem_wdata_q   <= 32'd0;
            rdata_q        <= 32'd0;
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 1'b0;
            rd_w_q         <= 5'd0;
            pc_plus4_w_q   <= 32'd0;
            alu_result_w_q <= 32'd0;
            read_data_w_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            rdata_q        <= rdata_d;
            reg_write_w_q  <= reg_write_w_d;
            result_src_w_q <= result_src_w_d;
            rd_w_q         <= rd_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
            alu_result_w_q <= alu_result_w_d;
            read_data_w_q  <= read_data_w_d;
        end
    end

    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign RegWriteW   = reg_write_w_q;
    assign ResultSrcW  = result_src_w_q;
    assign RD_W        = rd_w_q;
    assign PCPlus4W    = pc_plus4_w_q;
    assign ALU_ResultW = alu_result_w_q;
    assign ReadDataW   = read_data_w_q;

endmodule

// File: tb/tb_memory_cycle_hs.sv
// -----------------------------------------------------------------------------
// tb_memory_cycle_hs
// Self-checking bench for memory_cycle_hs. A bus responder acks each request a
// chosen number of cycles after dmem_req rises; expectations come from a
// transaction-level model (stall/req cycle counts, M/W contents, held ReadDataW).
// The timeout scenario is compiled in when MEM_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_memory_cycle_hs;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        StallM;
    logic        RegWriteW, ResultSrcW, BusErrW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    int total = 0;
    int bad   = 0;

    // Observations from the most recent instruction
    int          o_stall, o_req;
    logic [31:0] o_addr, o_wdata;
    logic        o_we, o_req_var, o_bub_rw, o_bub_err, o_hung;
    logic [4:0]  o_bub_rd;
    logic        req_trace[$];

    always #5 clk = ~clk;

    memory_cycle_hs #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
        .BusErrW(BusErrW)
    );

    // Present one instruction (called at a negedge) and hold it until it leaves M.
    // The responder acks on the k-th request cycle (0-based); noise adds stray acks
    // while dmem_req is low. Returns at the negedge after the instruction retired.
    task automatic run_instr(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                             input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu,
                             input int k, input logic [31:0] rv, input logic noise);
        int idx, c;
        logic stall, fin;
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
        PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
        o_stall = 0; o_req = 0; o_req_var = 1'b0; o_bub_rw = 1'b0; o_bub_err = 1'b0;
        o_bub_rd = RD_W; o_hung = 1'b0; o_addr = 32'd0; o_we = 1'b0; o_wdata = 32'd0;
        idx = 0; c = 0; fin = 1'b0;
        while (!fin) begin
            dmem_ack = 1'b0; dmem_rdata = ~rv;
            #1;
            req_trace.push_back(dmem_req);
            if (dmem_req) begin
                if (idx == 0) begin
                    o_addr = dmem_addr; o_we = dmem_we; o_wdata = dmem_wdata;
                end else if ({dmem_addr, dmem_we, dmem_wdata} !== {o_addr, o_we, o_wdata}) begin
                    o_req_var = 1'b1;
                end
                if (idx == k) begin
                    dmem_ack = 1'b1; dmem_rdata = rv;
                end
                idx++; o_req++;
            end else if (noise) begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            if (c > 0) begin
                o_bub_rw  = o_bub_rw | RegWriteW;
                o_bub_err = o_bub_err | BusErrW;
                o_bub_rd  = RD_W;
            end
            stall = StallM;
            if (stall) o_stall++;
            c++;
            @(posedge clk);
            if (!stall || c > 300) begin
                fin = 1'b1; o_hung = stall;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, RegWriteW, ResultSrcW, RD_W,
             PCPlus4W, ALU_ResultW, ReadDataW, BusErrW} !== 0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h rw=%b rs=%b rd=%0d pc=%h alu=%h rdw=%h err=%b want all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, RegWriteW, ResultSrcW, RD_W,
                     PCPlus4W, ALU_ResultW, ReadDataW, BusErrW);
        end
        total++;
        if (StallM !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", StallM); end
    endtask

    task automatic test_alu();
        run_instr(1'b1, 1'b0, 1'b0, 5'd5, 32'h8, 32'h0, 32'h1234, 0, 32'h0, 1'b1);
        total++;
        if ({RegWriteW, RD_W, ALU_ResultW, PCPlus4W} !== {1'b1, 5'd5, 32'h1234, 32'h8}) begin
            bad++;
            $display("FAIL alu_w: got rw=%b rd=%0d alu=%h pc=%h want 1 5 00001234 00000008",
                     RegWriteW, RD_W, ALU_ResultW, PCPlus4W);
        end
        total++;
        if (o_stall !== 0 || o_req !== 0) begin
            bad++; $display("FAIL alu_no_stall: got stall=%0d req=%0d want 0 0", o_stall, o_req);
        end
    endtask

    task automatic test_load();
        run_instr(1'b1, 1'b0, 1'b1, 5'd9, 32'h20, 32'h0, 32'h100, 2, 32'hCAFEF00D, 1'b1);
        total++;
        if (o_req !== 3 || o_we !== 1'b0 || o_addr !== 32'h100 || o_req_var !== 1'b0) begin
            bad++;
            $display("FAIL load_bus: got req=%0d we=%b addr=%h var=%b want 3 0 00000100 0",
                     o_req, o_we, o_addr, o_req_var);
        end
        total++;
        if (o_stall !== 4) begin bad++; $display("FAIL load_stall: got %0d want 4", o_stall); end
        total++;
        if ({ReadDataW, ResultSrcW, RegWriteW, RD_W} !== {32'hCAFEF00D, 1'b1, 1'b1, 5'd9}) begin
            bad++;
            $display("FAIL load_w: got rdw=%h rs=%b rw=%b rd=%0d want cafef00d 1 1 9",
                     ReadDataW, ResultSrcW, RegWriteW, RD_W);
        end
    endtask

    task automatic test_store();
        run_instr(1'b0, 1'b1, 1'b0, 5'd3, 32'h24, 32'hA5A5A5A5, 32'h40, 0, 32'h77777777, 1'b1);
        total++;
        if (o_req !== 1 || o_we !== 1'b1 || o_wdata !== 32'hA5A5A5A5 || o_addr !== 32'h40) begin
            bad++;
            $display("FAIL store_bus: got req=%0d we=%b wdata=%h addr=%h want 1 1 a5a5a5a5 00000040",
                     o_req, o_we, o_wdata, o_addr);
        end
        total++;
        if (o_stall !== 2 || o_bub_rw !== 1'b0) begin
            bad++; $display("FAIL store_stall: got stall=%0d bubble_rw=%b want 2 0", o_stall, o_bub_rw);
        end
        total++;
        if (ReadDataW !== 32'd0 || RegWriteW !== 1'b0) begin
            bad++; $display("FAIL store_w: got rdw=%h rw=%b want 0 0", ReadDataW, RegWriteW);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] first_rdw;
        logic [5:0]  tr;
        req_trace.delete();
        run_instr(1'b1, 1'b0, 1'b1, 5'd1, 32'h30, 32'h0, 32'h200, 0, 32'h11111111, 1'b0);
        first_rdw = ReadDataW;
        run_instr(1'b1, 1'b0, 1'b1, 5'd2, 32'h34, 32'h0, 32'h204, 0, 32'h22222222, 1'b0);
        tr = 6'd0;
        for (int i = 0; i < req_trace.size() && i < 6; i++) tr[5 - i] = req_trace[i];
        total++;
        if (req_trace.size() !== 6 || tr !== 6'b010010) begin
            bad++; $display("FAIL b2b_req_pattern: got n=%0d %b want 6 010010", req_trace.size(), tr);
        end
        total++;
        if (first_rdw !== 32'h11111111 || ReadDataW !== 32'h22222222 || RD_W !== 5'd2) begin
            bad++;
            $display("FAIL b2b_data: got %h %h rd=%0d want 11111111 22222222 2", first_rdw, ReadDataW, RD_W);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 1'b1; RD_M = 5'd7; ALU_ResultM = 32'h300;
        dmem_ack = 1'b0;
        @(posedge clk);          // IDLE -> BUSY
        @(negedge clk);          // first BUSY cycle
        @(posedge clk);
        @(negedge clk);          // second BUSY cycle
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0; RD_M = 5'd0;
        PCPlus4M = 32'd0; WriteDataM = 32'd0; ALU_ResultM = 32'd0;
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        total++;
        if ({dmem_req, StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, BusErrW} !== 0) begin
            bad++;
            $display("FAIL rst_mid_state: got req=%b stall=%b rw=%b rs=%b rd=%0d pc=%h alu=%h rdw=%h err=%b want all 0",
                     dmem_req, StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, BusErrW);
        end
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        total++;
        if (dmem_req !== 1'b0 || ReadDataW !== 32'd0 || StallM !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_ack_ignored: got req=%b rdw=%h stall=%b want 0 0 0", dmem_req, ReadDataW, StallM);
        end
        @(negedge clk);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        run_instr(1'b1, 1'b0, 1'b1, 5'd12, 32'h50, 32'h0, 32'h400, 1000, 32'h5A5A5A5A, 1'b0);
        total++;
        if (o_hung !== 1'b0 || o_req !== TO || o_stall !== TO + 1) begin
            bad++;
            $display("FAIL timeout_cycles: got hung=%b req=%0d stall=%0d want 0 %0d %0d", o_hung, o_req, o_stall, TO, TO + 1);
        end
        total++;
        if ({BusErrW, RegWriteW, ReadDataW} !== {1'b1, 1'b0, 32'd0}) begin
            bad++; $display("FAIL timeout_w: got err=%b rw=%b rdw=%h want 1 0 0", BusErrW, RegWriteW, ReadDataW);
        end
        run_instr(1'b1, 1'b0, 1'b0, 5'd13, 32'h54, 32'h0, 32'h9, 0, 32'h0, 1'b0);
        total++;
        if ({BusErrW, RegWriteW, RD_W} !== {1'b0, 1'b1, 5'd13}) begin
            bad++; $display("FAIL timeout_resume: got err=%b rw=%b rd=%0d want 0 1 13", BusErrW, RegWriteW, RD_W);
        end
    endtask
`endif

    task automatic test_random();
        logic        rw, mw, rs, acc, tmo;
        logic [4:0]  rd, m_rd;
        logic [31:0] pc, wd, alu, rv, e_rdw, m_rdw;
        int          typ, k, e_stall, e_req, r;
        do_reset();
        m_rdw = 32'd0; m_rd = 5'd0;
        for (int i = 0; i < 60; i++) begin
            rw  = 1'($urandom_range(0, 1));
            typ = $urandom_range(0, 3);
            mw  = (typ == 2 || typ == 3);
            rs  = (typ == 1 || typ == 3);
            rd  = 5'($urandom_range(0, 31));
            pc = $urandom; wd = $urandom; alu = $urandom; rv = $urandom;
            r = $urandom_range(0, 7);
`ifdef MEM_TIMEOUT_EN
            k = (r == 7) ? 1000 : (r == 6) ? TO - 1 : $urandom_range(0, 5);
`else
            k = (r == 7) ? 9 : $urandom_range(0, 5);
`endif
            run_instr(rw, mw, rs, rd, pc, wd, alu, k, rv, 1'b1);
            acc = mw | rs;
`ifdef MEM_TIMEOUT_EN
            tmo = acc && (k > TO - 1);
`else
            tmo = 1'b0;
`endif
            e_stall = !acc ? 0 : tmo ? TO + 1 : k + 2;
            e_req   = !acc ? 0 : tmo ? TO : k + 1;
            e_rdw   = !acc ? m_rdw : (mw || tmo) ? 32'd0 : rv;
            total++;
            if (o_hung !== 1'b0 || o_stall !== e_stall || o_req !== e_req) begin
                bad++;
                $display("FAIL rand_timing[%0d]: got hung=%b stall=%0d req=%0d want 0 %0d %0d",
                         i, o_hung, o_stall, o_req, e_stall, e_req);
            end
            if (acc) begin
                total++;
                if ({o_addr, o_we, o_wdata, o_req_var} !== {alu, mw, wd, 1'b0}) begin
                    bad++;
                    $display("FAIL rand_bus[%0d]: got addr=%h we=%b wdata=%h var=%b want %h %b %h 0",
                             i, o_addr, o_we, o_wdata, o_req_var, alu, mw, wd);
                end
                total++;
                if ({o_bub_rw, o_bub_err, o_bub_rd} !== {1'b0, 1'b0, m_rd}) begin
                    bad++;
                    $display("FAIL rand_bubble[%0d]: got rw=%b err=%b rd=%0d want 0 0 %0d",
                             i, o_bub_rw, o_bub_err, o_bub_rd, m_rd);
                end
            end
            total++;
            if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, BusErrW} !==
                {rw & ~tmo, rs, rd, pc, alu, e_rdw, tmo}) begin
                bad++;
                $display("FAIL rand_w[%0d]: got rw=%b rs=%b rd=%0d pc=%h alu=%h rdw=%h err=%b want %b %b %0d %h %h %h %b",
                         i, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, BusErrW,
                         rw & ~tmo, rs, rd, pc, alu, e_rdw, tmo);
            end
            m_rdw = e_rdw;
            m_rd  = rd;
        end
    endtask

    initial begin
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0; RD_M = 5'd0;
        PCPlus4M = 32'd0; WriteDataM = 32'd0; ALU_ResultM = 32'd0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
